// File: rtl/muldiv_pkg.sv
// Shared encodings, state enum and result payload for the HI/LO multiply/divide engine.
package muldiv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = 6;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Two's-complement negate when requested.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic c);
        return c ? XLEN'(-v) : v;
    endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per step, MSB first.
module div_radix2_core
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] divisor_q;
    logic [XLEN:0]   trial;

    // Partial remainder never reaches 2*divisor, so 33 bits hold the trial without loss.
    assign trial = {remainder, quotient[XLEN-1]} - {1'b0, divisor_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quotient  <= '0;
            remainder <= '0;
            divisor_q <= '0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            divisor_q <= divisor;
        end else if (step) begin
            if (!trial[XLEN]) begin
                remainder <= trial[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b1};
            end else begin
                remainder <= {remainder[XLEN-2:0], quotient[XLEN-1]};
                quotient  <= {quotient[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine writing {HI,LO} with a single strobe.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic [63:0]     hl_data,
    output logic            hl_write_enable
);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic              latch, core_load, core_step, result_we;
    hilo_t             result, mul_res, div_res;
    logic [63:0]       mul_a, mul_b, product;
    logic [XLEN-1:0]   core_q, core_r;
    logic              div_signed;

    // Sign-extending to 64 bits gives the 33-bit extended product modulo 2^64.
    assign mul_a   = {{XLEN{(op_q == OP_MULT) & a_q[XLEN-1]}}, a_q};
    assign mul_b   = {{XLEN{(op_q == OP_MULT) & b_q[XLEN-1]}}, b_q};
    assign product = mul_a * mul_b;
    assign mul_res = product;

    assign div_signed = (op_q == OP_DIV);
    assign div_res.hi = neg_if(core_r, div_signed & a_q[XLEN-1]);
    assign div_res.lo = (b_q == '0) ? '1
                      : neg_if(core_q, div_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]));

    div_radix2_core u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .step      (core_step),
        .dividend  (neg_if(src_a, (op == OP_DIV) & src_a[XLEN-1])),
        .divisor   (neg_if(src_b, (op == OP_DIV) & src_b[XLEN-1])),
        .quotient  (core_q),
        .remainder (core_r)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            op_q            <= '0;
            a_q             <= '0;
            b_q             <= '0;
            busy            <= 1'b0;
            hl_write_enable <= 1'b0;
            hl_data         <= '0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            busy            <= (state_nx != IDLE);
            hl_write_enable <= result_we;
            if (latch) begin
                op_q <= op;
                a_q  <= src_a;
                b_q  <= src_b;
            end
            if (result_we) hl_data <= result;
        end
    end

    // Next state; flush overrides everything except a pulse already on the wire.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        latch     = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        result_we = 1'b0;
        result    = mul_res;
        case (state)
            IDLE: begin
                if (start) begin
                    latch  = 1'b1;
                    cnt_nx = '0;
                    if (op[1]) begin
                        state_nx  = DIV;
                        core_load = 1'b1;
                    end else begin
                        state_nx = MUL;
                    end
                end
            end
            MUL: begin
                if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
                    state_nx  = DONE;
                    result_we = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DIV: begin
                core_step = 1'b1;
                if (cnt == CNT_W'(DIV_ITERS - 1)) state_nx = FIX;
                else                              cnt_nx   = cnt + CNT_W'(1);
            end
            FIX: begin
                state_nx  = DONE;
                result_we = 1'b1;
                result    = div_res;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx  = IDLE;
            latch     = 1'b0;
            core_load = 1'b0;
            core_step = 1'b0;
            result_we = 1'b0;
        end
    end

endmodule
